// File: rtl/hack_screen_reader.sv
// Streams the Hack screen map out of hack_memory as a 1-bit pixel stream with valid/ready.
// Optional build macro HACK_SCREEN_FRAME_CNT_EN adds a 16-bit completed-frame counter output.
module hack_screen_reader #(
  parameter int SCREEN_BASE   = 16384,
  parameter int WORDS_PER_ROW = 32,
  parameter int ROWS          = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  output logic        rd_en,
  output logic [14:0] rd_addr,
  input  logic [15:0] rd_data,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic        pix_data,
  output logic [8:0]  pix_x,
  output logic [7:0]  pix_y,
  output logic        frame_end,
  output logic        busy
`ifdef HACK_SCREEN_FRAME_CNT_EN
  ,
  output logic [15:0] frame_cnt
`endif
);

  localparam int FRAME_WORDS = WORDS_PER_ROW * ROWS;
  localparam int OFF_W       = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
  localparam logic [OFF_W-1:0] LAST_OFF = OFF_W'(FRAME_WORDS - 1);
  localparam logic [8:0] X_MAX = 9'(WORDS_PER_ROW * 16 - 1);
  localparam logic [7:0] Y_MAX = 8'(ROWS - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, DRAIN = 2'd2} state_t;

  state_t           state, state_next;
  logic [OFF_W-1:0] next_off;       // offset of the next word to fetch
  logic             resp_pending;   // rd_data carries a response this cycle
  logic [15:0]      shift_word;     // word being streamed, current pixel in bit 0
  logic [15:0]      hold_word;
  logic             hold_valid;
  logic             xfer, word_done, shifter_free, start, issue;
  logic [2:0]       occupancy;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    xfer         = pix_valid && pix_ready;
    word_done    = xfer && (pix_x[3:0] == 4'hf);
    shifter_free = !pix_valid || word_done;
    // Words held or in flight once this edge's consumption is accounted for.
    occupancy    = 3'(pix_valid) + 3'(hold_valid) + 3'(rd_en) + 3'(resp_pending)
                 - 3'(word_done);
    start        = 1'b0;
    issue        = 1'b0;
    state_next   = state;
    case (state)
      IDLE: if (enable) begin
        start      = 1'b1;
        state_next = SCAN;
      end
      SCAN: if (occupancy < 3'd2) begin
        // Offset 0 here means the previous frame is fully fetched.
        if (next_off == '0 && !enable) state_next = DRAIN;
        else                           issue      = 1'b1;
      end
      DRAIN: if (occupancy == 3'd0) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign pix_data  = shift_word[0];
  assign frame_end = pix_valid && (pix_x == X_MAX) && (pix_y == Y_MAX);
  assign busy      = (state != IDLE);

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the word buffers are reset too so pix_data is defined out of reset.
      state        <= IDLE;
      rd_en        <= 1'b0;
      rd_addr      <= 15'(SCREEN_BASE);
      next_off     <= '0;
      resp_pending <= 1'b0;
      shift_word   <= '0;
      hold_word    <= '0;
      hold_valid   <= 1'b0;
      pix_valid    <= 1'b0;
      pix_x        <= '0;
      pix_y        <= '0;
    end else begin
      state        <= state_next;
      resp_pending <= rd_en;
      rd_en        <= start || issue;
      if (start) begin
        rd_addr  <= 15'(SCREEN_BASE);
        next_off <= OFF_W'(1);
      end else if (issue) begin
        rd_addr  <= 15'(SCREEN_BASE + int'(next_off));
        next_off <= (next_off == LAST_OFF) ? '0 : next_off + 1'b1;
      end

      if (shifter_free) begin
        if (hold_valid) begin
          shift_word <= hold_word;
          pix_valid  <= 1'b1;
          hold_valid <= resp_pending;
          if (resp_pending) hold_word <= rd_data;
        end else if (resp_pending) begin
          shift_word <= rd_data;
          pix_valid  <= 1'b1;
        end else begin
          shift_word <= '0;
          pix_valid  <= 1'b0;
        end
      end else begin
        if (xfer) shift_word <= shift_word >> 1;
        if (resp_pending) begin
          hold_word  <= rd_data;
          hold_valid <= 1'b1;
        end
      end

      if (xfer) begin
        if (pix_x == X_MAX) begin
          pix_x <= '0;
          pix_y <= (pix_y == Y_MAX) ? '0 : pix_y + 1'b1;
        end else begin
          pix_x <= pix_x + 1'b1;
        end
      end
    end
  end

`ifdef HACK_SCREEN_FRAME_CNT_EN
  always_ff @(posedge clk) begin
    if (reset)                  frame_cnt <= '0;
    else if (xfer && frame_end) frame_cnt <= frame_cnt + 1'b1;
  end
`endif

endmodule

// File: doc/hack_screen_reader.md
Name: hack_screen_reader

Overview:
- Read-side initiator for the Hack screen region of hack_memory.
- Walks the screen map sequentially and issues word reads to the memory's read port.
- Serialises each 16-bit word into a pixel stream with valid/ready handshake, for a display or video encoder.
- Sits between hack_memory and the display output; it only reads and never writes memory.

Parameters:
SCREEN_BASE, 16384, absolute word address of screen pixel (0,0)
WORDS_PER_ROW, 32, words per screen row (512 px / 16)
ROWS, 256, rows per frame

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
enable  input  1  level; start/continue frame scanning
rd_en  output  1  memory read strobe
rd_addr  output  15  absolute memory word address
rd_data  input  16  memory read data, valid exactly 1 cycle after rd_en
pix_valid  output  1  pixel available
pix_ready  input  1  downstream accepts pixel
pix_data  output  1  pixel value (1 = black)
pix_x  output  9  column of current pixel, 0..511
pix_y  output  8  row of current pixel, 0..255
frame_end  output  1  high with the last pixel (511,255) of a frame
busy  output  1  high from frame start until last pixel is accepted

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on reset, and takes priority over all other inputs.
- Reset values: state IDLE, rd_en=0, rd_addr=SCREEN_BASE, pix_valid=0, pix_data=0, pix_x=0, pix_y=0, frame_end=0, busy=0. Buffer is emptied and any in-flight read is discarded.
- States:
  - IDLE: enable=1 sampled at edge E -> rd_en=1, rd_addr=SCREEN_BASE, busy=1, go to SCAN.
  - SCAN: prefetch and stream.
  - DRAIN: enable is low and the final word has been fetched; finish streaming, then return to IDLE.
- Start latency: rd_data is captured at edge E+2 and pix_valid=1 after edge E+2.
- Prefetch:
  - 2-word buffer, including the word currently in the shifter.
  - rd_en is issued only when buffered words plus outstanding reads is less than 2.
  - Each read increments the word offset.
  - Offset WORDS_PER_ROW*ROWS-1 wraps to 0 (rd_addr 24575 -> 16384) if enable=1 at that point; otherwise no further reads are issued and the state goes to DRAIN.
- Pixel order: pixel column c of a word is bit (c mod 16) of that word; bit 0 goes out first.
- Handshake:
  - A transfer occurs when pix_valid && pix_ready.
  - pix_data, pix_x and pix_y are held stable while pix_valid && !pix_ready.
  - pix_valid never drops without a transfer, except on reset.
- Throughput: with pix_ready held at 1, one pixel per cycle with no bubbles, including across word, row and frame boundaries.
- Counters: pix_x increments on each transfer. At 511 it wraps to 0 and pix_y increments. At (511,255) both wrap to 0.
- frame_end: combinationally equal to (pix_x==511 && pix_y==255) while pix_valid=1.
- enable dropped mid-frame: the current frame completes fully, then the block goes to IDLE with busy=0. No rd_en is issued for the next frame.
- enable re-asserted during DRAIN: ignored until IDLE is reached.
- Reset mid-frame: on the next cycle all outputs hold their reset values, and no rd_en is issued until enable is sampled again.
- Memory contents are sampled at read time; writes to already-fetched words do not affect the current frame.

Optional Feature:
- Macro: HACK_SCREEN_FRAME_CNT_EN.
- Defined:
  - Adds output frame_cnt, 16 bits, reset to 0.
  - frame_cnt increments on the transfer of pixel (511,255) and wraps 65535 -> 0.
- Undefined: the port and counter are absent and the remaining behaviour is identical.

Test Plan:
1. Reset asserted for 2 cycles with enable=1 -> rd_en=0, pix_valid=0, pix_x=pix_y=0, busy=0, frame_end=0.
2. Screen word 0 = 16'h0001, word 1 = 16'h8000, pix_ready=1, enable pulse -> first rd_addr=16384, then 16385; pix_data=1 at (0,0), 0 at (1..30,0), 1 at (31,0); first pix_valid exactly 2 cycles after the edge that samples enable.
3. pix_ready pattern 1,0,0 repeating -> pix_data, pix_x and pix_y are stable on stalled cycles; outstanding plus buffered words never exceeds 2; pixel sequence matches the ready=1 run.
4. enable held 1 for 2 frames with pix_ready=1 -> 131072 transfers per frame with no gaps; frame_end is a single-cycle pulse at (511,255); the read after 24575 is 16384; pix_y wraps to 0.
5. enable dropped at pixel (100,10) -> frame completes through (511,255), then busy=0, no further rd_en, state IDLE.
6. reset at pixel (200,50) -> next cycle all outputs equal reset values; an rd_data response arriving afterwards is ignored; a new enable restarts at rd_addr=16384, pixel (0,0).
